// File: rtl/traffic_light_monitor.sv
// Passive monitor for a G/Y/R traffic-light controller: checks lamp encoding,
// phase order and per-phase dwell, and counts clean full G->Y->R->G loops.
module traffic_light_monitor #(
  parameter int unsigned G_CYCLES = 600000001,
  parameter int unsigned Y_CYCLES = 200000001,
  parameter int unsigned R_CYCLES = 600000001,
  parameter int unsigned TOL      = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        green,
  input  logic        yellow,
  input  logic        red,
  input  logic        err_clr,
  output logic [1:0]  phase,
  output logic        seq_err,
  output logic        time_err,
  output logic        lamp_err,
  output logic        err_pulse,
  output logic [15:0] loop_cnt
);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_RED    = 2'd3
  } state_t;

  // Early limit clamps at zero; late limit is the first dwell that is too long.
  localparam logic [CNT_W-1:0] G_LO = CNT_W'((G_CYCLES >= TOL) ? (G_CYCLES - TOL) : 0);
  localparam logic [CNT_W-1:0] Y_LO = CNT_W'((Y_CYCLES >= TOL) ? (Y_CYCLES - TOL) : 0);
  localparam logic [CNT_W-1:0] R_LO = CNT_W'((R_CYCLES >= TOL) ? (R_CYCLES - TOL) : 0);
  localparam logic [CNT_W-1:0] G_HI = CNT_W'(G_CYCLES + TOL + 1);
  localparam logic [CNT_W-1:0] Y_HI = CNT_W'(Y_CYCLES + TOL + 1);
  localparam logic [CNT_W-1:0] R_HI = CNT_W'(R_CYCLES + TOL + 1);

  state_t           state, state_nxt, obs;
  logic [CNT_W-1:0] dwell, dwell_nxt, dwell_inc, lim_lo, lim_hi;
  logic             untimed, untimed_nxt;
  logic             wd_hit, wd_hit_nxt;
  logic             loop_clean, loop_clean_nxt;
  logic             bad_prev;
  logic             valid, same, legal, illegal;
  logic             wd_ev, early_ev, lamp_ev, any_ev, loop_inc;
  logic             seq_err_nxt, time_err_nxt, lamp_err_nxt;
  logic [15:0]      loop_cnt_nxt;

  assign phase = state;

  // State register and all registered datapath/outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_SYNC;
      dwell      <= '0;
      untimed    <= 1'b1;
      wd_hit     <= 1'b0;
      loop_clean <= 1'b0;
      bad_prev   <= 1'b0;
      seq_err    <= 1'b0;
      time_err   <= 1'b0;
      lamp_err   <= 1'b0;
      err_pulse  <= 1'b0;
      loop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      dwell      <= dwell_nxt;
      untimed    <= untimed_nxt;
      wd_hit     <= wd_hit_nxt;
      loop_clean <= loop_clean_nxt;
      bad_prev   <= ~valid;
      seq_err    <= seq_err_nxt;
      time_err   <= time_err_nxt;
      lamp_err   <= lamp_err_nxt;
      err_pulse  <= any_ev;
      loop_cnt   <= loop_cnt_nxt;
    end
  end

  // Lamp decode, transition classification and error events
  always_comb begin
    valid = ({green, yellow, red} == 3'b100) || ({green, yellow, red} == 3'b010) ||
            ({green, yellow, red} == 3'b001);
    obs = S_SYNC;
    if (green)       obs = S_GREEN;
    else if (yellow) obs = S_YELLOW;
    else if (red)    obs = S_RED;

    lim_lo = G_LO;
    lim_hi = G_HI;
    case (state)
      S_YELLOW: begin lim_lo = Y_LO; lim_hi = Y_HI; end
      S_RED:    begin lim_lo = R_LO; lim_hi = R_HI; end
      default:  begin lim_lo = G_LO; lim_hi = G_HI; end
    endcase

    same    = valid && (state != S_SYNC) && (obs == state);
    legal   = valid && (((state == S_GREEN)  && (obs == S_YELLOW)) ||
                        ((state == S_YELLOW) && (obs == S_RED))    ||
                        ((state == S_RED)    && (obs == S_GREEN)));
    illegal = valid && (state != S_SYNC) && !same && !legal;

    dwell_inc = (dwell == '1) ? dwell : dwell + CNT_W'(1);
    wd_ev     = same && !untimed && !wd_hit && (dwell_inc == lim_hi);
    early_ev  = legal && !untimed && !wd_hit && (dwell < lim_lo);
    lamp_ev   = !valid && !bad_prev;
    any_ev    = wd_ev || early_ev || lamp_ev || illegal;
    loop_inc  = legal && (state == S_RED) && loop_clean && !early_ev;
  end

  // Next-state and phase bookkeeping
  always_comb begin
    state_nxt      = state;
    dwell_nxt      = dwell;
    untimed_nxt    = untimed;
    wd_hit_nxt     = wd_hit;
    loop_clean_nxt = loop_clean;
    if (!valid) begin
      state_nxt      = S_SYNC;
      dwell_nxt      = '0;
      untimed_nxt    = 1'b1;
      wd_hit_nxt     = 1'b0;
      loop_clean_nxt = 1'b0;
    end else if (state == S_SYNC) begin
      state_nxt   = obs;
      dwell_nxt   = CNT_W'(1);
      untimed_nxt = 1'b1;
      wd_hit_nxt  = 1'b0;
    end else if (same) begin
      dwell_nxt      = dwell_inc;
      wd_hit_nxt     = wd_hit || wd_ev;
      loop_clean_nxt = loop_clean && !wd_ev;
    end else if (legal) begin
      state_nxt      = obs;
      dwell_nxt      = CNT_W'(1);
      untimed_nxt    = 1'b0;
      wd_hit_nxt     = 1'b0;
      loop_clean_nxt = (obs == S_GREEN) ? 1'b1 : (loop_clean && !early_ev);
    end else begin
      state_nxt      = obs;
      dwell_nxt      = CNT_W'(1);
      untimed_nxt    = 1'b1;
      wd_hit_nxt     = 1'b0;
      loop_clean_nxt = 1'b0;
    end
  end

  // Sticky flags (new error beats clear) and saturating loop counter
  always_comb begin
    seq_err_nxt  = illegal || (seq_err && !err_clr);
    time_err_nxt = wd_ev || early_ev || (time_err && !err_clr);
    lamp_err_nxt = lamp_ev || (lamp_err && !err_clr);
    loop_cnt_nxt = loop_cnt;
    if (loop_inc && (loop_cnt != 16'hFFFF)) loop_cnt_nxt = loop_cnt + 16'd1;
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus random phase runs,
// every cycle compared against a phase-run reference model.
module tb_traffic_light_monitor;

  localparam int unsigned TOL = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        green = 1'b0, yellow = 1'b0, red = 1'b0, err_clr = 1'b0;
  logic [1:0]  phase;
  logic        seq_err, time_err, lamp_err, err_pulse;
  logic [15:0] loop_cnt;

  traffic_light_monitor #(
    .G_CYCLES(6), .Y_CYCLES(3), .R_CYCLES(6), .TOL(TOL), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .green(green), .yellow(yellow), .red(red),
    .err_clr(err_clr), .phase(phase), .seq_err(seq_err), .time_err(time_err),
    .lamp_err(lamp_err), .err_pulse(err_pulse), .loop_cnt(loop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int expc[4] = '{0, 6, 3, 6};

  // Reference model: current phase run (phase id, length, timed?) and flags
  int m_phase, m_run, m_loop;
  bit m_timed, m_hit, m_clean, m_prev_bad;
  bit m_seq, m_time, m_lamp, m_pulse;

  task automatic model(input bit rst, input logic [2:0] lamps, input bit clr);
    int n, obs, lo;
    bit s, t, l, early;
    if (rst) begin
      m_phase = 0; m_run = 0; m_loop = 0; m_timed = 0; m_hit = 0; m_clean = 0;
      m_prev_bad = 0; m_seq = 0; m_time = 0; m_lamp = 0; m_pulse = 0;
      return;
    end
    s = 0; t = 0; l = 0;
    n = int'(lamps[2]) + int'(lamps[1]) + int'(lamps[0]);
    obs = lamps[2] ? 1 : (lamps[1] ? 2 : 3);
    if (n != 1) begin
      l = !m_prev_bad;
      m_prev_bad = 1; m_phase = 0; m_run = 0; m_clean = 0; m_timed = 0; m_hit = 0;
    end else begin
      m_prev_bad = 0;
      if (m_phase == 0) begin
        m_phase = obs; m_run = 1; m_timed = 0; m_hit = 0;
      end else if (obs == m_phase) begin
        m_run++;
        if (m_timed && !m_hit && m_run == expc[m_phase] + int'(TOL) + 1) begin
          t = 1; m_hit = 1; m_clean = 0;
        end
      end else if (obs == m_phase % 3 + 1) begin
        lo = expc[m_phase] - int'(TOL);
        if (lo < 0) lo = 0;
        early = m_timed && !m_hit && (m_run < lo);
        if (early) begin t = 1; m_clean = 0; end
        if (m_phase == 3 && m_clean && m_loop < 65535) m_loop++;
        m_phase = obs; m_run = 1; m_timed = 1; m_hit = 0;
        if (obs == 1) m_clean = 1;
      end else begin
        s = 1; m_phase = obs; m_run = 1; m_timed = 0; m_hit = 0; m_clean = 0;
      end
    end
    m_seq  = s | (m_seq & !clr);
    m_time = t | (m_time & !clr);
    m_lamp = l | (m_lamp & !clr);
    m_pulse = s | t | l;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("phase", longint'(phase), longint'(m_phase));
    check("seq_err", longint'(seq_err), longint'(m_seq));
    check("time_err", longint'(time_err), longint'(m_time));
    check("lamp_err", longint'(lamp_err), longint'(m_lamp));
    check("err_pulse", longint'(err_pulse), longint'(m_pulse));
    check("loop_cnt", longint'(loop_cnt), longint'(m_loop));
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after
  task automatic step(input bit rst, input logic [2:0] lamps, input bit clr);
    reset = rst; {green, yellow, red} = lamps; err_clr = clr;
    @(posedge clk);
    model(rst, lamps, clr);
    #1;
    compare();
  endtask

  task automatic hold(input logic [2:0] lamps, input int n);
    for (int i = 0; i < n; i++) step(1'b0, lamps, 1'b0);
  endtask

  localparam logic [2:0] LG = 3'b100, LY = 3'b010, LR = 3'b001;

  initial begin
    int sp, nxt, len, a, k;
    logic [2:0] bad;
    // 1: clean loop
    step(1'b1, LR, 1'b0); step(1'b1, LR, 1'b0);
    check("rst_phase", longint'(phase), 0);
    check("rst_loop", longint'(loop_cnt), 0);
    hold(LR, 4); hold(LG, 6); hold(LY, 3); hold(LR, 6); hold(LG, 1);
    check("t1_phase", longint'(phase), 1);
    check("t1_loop", longint'(loop_cnt), 1);
    check("t1_flags", longint'({seq_err, time_err, lamp_err}), 0);
    // 2: Green overstays
    hold(LG, 6);
    check("t2_time", longint'(time_err), 1);
    check("t2_pulse", longint'(err_pulse), 1);
    hold(LY, 3); hold(LR, 6); hold(LG, 1);
    check("t2_loop", longint'(loop_cnt), 1);
    step(1'b0, LG, 1'b1);
    check("clr_flags", longint'({seq_err, time_err, lamp_err}), 0);
    // 3: Yellow too short
    hold(LG, 4); hold(LY, 2); hold(LR, 1);
    check("t3_time", longint'(time_err), 1);
    check("t3_pulse", longint'(err_pulse), 1);
    check("t3_phase", longint'(phase), 3);
    // 4: Green skips Yellow
    step(1'b0, LR, 1'b1); hold(LR, 4); hold(LG, 1); hold(LR, 1);
    check("t4_seq", longint'(seq_err), 1);
    check("t4_phase", longint'(phase), 3);
    hold(LR, 5); hold(LG, 1);
    check("t4_time", longint'(time_err), 0);
    check("t4_loop", longint'(loop_cnt), 1);
    // 5: two lamps lit
    hold(LG, 2); hold(3'b110, 1);
    check("t5_lamp", longint'(lamp_err), 1);
    check("t5_phase", longint'(phase), 0);
    hold(LG, 9); hold(LY, 1);
    check("t5_time", longint'(time_err), 0);
    // 6: clear vs new error, clear alone, reset mid-Yellow
    hold(LY, 2); hold(LR, 1); step(1'b0, LY, 1'b1);
    check("t6_seq", longint'(seq_err), 1);
    step(1'b0, LY, 1'b1);
    check("t6_clr", longint'({seq_err, time_err, lamp_err}), 0);
    check("t6_loop", longint'(loop_cnt), 1);
    hold(LY, 1); step(1'b1, LY, 1'b0);
    check("t6_rst", longint'({phase, seq_err, time_err, lamp_err, err_pulse}), 0);
    check("t6_rst_loop", longint'(loop_cnt), 0);

    // Random phase runs around the nominal dwell, with faults mixed in
    sp = 2;
    for (int r = 0; r < 300; r++) begin
      a = int'($urandom_range(0, 99));
      if (a < 4) begin
        step(1'b1, LG, 1'b0);
      end else if (a < 12) begin
        k = int'($urandom_range(1, 2));
        case ($urandom_range(0, 4))
          0: bad = 3'b000;
          1: bad = 3'b011;
          2: bad = 3'b101;
          3: bad = 3'b110;
          default: bad = 3'b111;
        endcase
        hold(bad, k);
      end else begin
        nxt = (a < 20) ? ((sp + 1) % 3 + 1) : (sp % 3 + 1);
        sp = nxt;
        len = expc[sp] + int'($urandom_range(0, 4)) - 2;
        if (len < 1) len = 1;
        for (int i = 0; i < len; i++)
          step(1'b0, (sp == 1) ? LG : ((sp == 2) ? LY : LR), ($urandom_range(0, 19) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
